// File: rtl/dram_ctrl.sv
// 68040 FPM/EDO DRAM controller: decodes a bus cycle, runs RAS/CAS timing per bank,
// page-mode line bursts, CBR refresh, and holds one request that arrives while busy.
// state | meaning
// IDLE  | strobes high; refresh first, then latched or new request
// RCD   | row open, waiting T_RCD; column driven on DRAMA one cycle before CAS
// CASL  | CAS lanes low for T_CAS; nTA low in the last cycle of the beat
// CASH  | CAS high for T_CP between line beats
// PRE   | all strobes high for T_RP
// REFC  | CBR: all CAS low before RAS
// REFR  | CBR: all RAS low for T_RAS_REF
module dram_ctrl #(
  parameter int NBANK     = 4,
  parameter int MA_W      = 11,
  parameter int T_RCD     = 2,
  parameter int T_CAS     = 2,
  parameter int T_CP      = 1,
  parameter int T_RP      = 2,
  parameter int T_RAS_REF = 3,
  parameter int REF_INT   = 390,
  parameter bit BURST_EN  = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          A,
  input  logic [1:0]           TT,
  input  logic [1:0]           SIZ,
  input  logic                 RW,
  input  logic                 nTS,
  input  logic                 SEL,
  input  logic                 nMI,
  output logic                 nTA,
  output logic                 nTBI,
  output logic [MA_W-1:0]      DRAMA,
  output logic [NBANK-1:0]     nRAS,
  output logic [4*NBANK-1:0]   nCAS,
  output logic                 DRAMRW
);
  localparam int BW  = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int CW  = 8;
  localparam int RFW = $clog2(REF_INT + 1);
  localparam logic [CW-1:0] C_RCD = CW'(T_RCD);
  localparam logic [CW-1:0] C_CAS = CW'(T_CAS - 1);
  localparam logic [CW-1:0] C_CP  = CW'(T_CP - 1);
  localparam logic [CW-1:0] C_RP  = CW'(T_RP - 1);
  localparam logic [CW-1:0] C_REF = CW'(T_RAS_REF - 1);
  localparam logic [RFW-1:0] REF_LAST = RFW'(REF_INT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RCD, S_CASL, S_CASH, S_PRE, S_REFC, S_REFR} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        beat_q, beat_d;
  logic [RFW-1:0]    ref_cnt_q, ref_cnt_d;
  logic              ref_pend_q, ref_pend_d, req_pend_q, req_pend_d;
  logic [BW-1:0]     lat_bank_q, lat_bank_d, bank_q, bank_d;
  logic [MA_W-1:0]   lat_row_q, lat_row_d, lat_col_q, lat_col_d, col_q, col_d;
  logic [3:0]        lat_mask_q, lat_mask_d, mask_q, mask_d;
  logic              lat_line_q, lat_line_d, line_q, line_d, lat_rw_q, lat_rw_d;
  logic              nta_q, nta_d, ntbi_q, ntbi_d, dramrw_q, dramrw_d;
  logic [MA_W-1:0]   drama_q, drama_d;
  logic [NBANK-1:0]  nras_q, nras_d;
  logic [4*NBANK-1:0] ncas_q, ncas_d;

  logic              new_req, tbi_beat;
  logic [BW-1:0]     in_bank, src_bank;
  logic [MA_W-1:0]   in_row, in_col, src_row, src_col, col_next;
  logic [3:0]        in_mask, src_mask;
  logic              in_line, src_line, src_rw;
  logic              unused_bits;

  function automatic logic [3:0] lane_mask(input logic [1:0] siz, input logic [1:0] a, input logic rw);
    if (rw) return 4'hF;
    case (siz)
      2'b01:   return 4'b0001 << a;
      2'b10:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [4*NBANK-1:0] cas_pattern(input logic [BW-1:0] bank, input logic [3:0] mask);
    logic [4*NBANK-1:0] m;
    m = {{(4*NBANK-4){1'b0}}, mask} << (4 * bank);
    return ~m;
  endfunction

  assign new_req  = !nTS && SEL && !TT[1];
  assign in_bank  = A[2+2*MA_W +: BW];
  assign in_row   = A[2+MA_W +: MA_W];
  assign in_col   = A[2 +: MA_W];
  assign in_mask  = lane_mask(SIZ, A[1:0], RW);
  assign in_line  = (SIZ == 2'b11);
  assign src_bank = req_pend_q ? lat_bank_q : in_bank;
  assign src_row  = req_pend_q ? lat_row_q  : in_row;
  assign src_col  = req_pend_q ? lat_col_q  : in_col;
  assign src_mask = req_pend_q ? lat_mask_q : in_mask;
  assign src_line = req_pend_q ? lat_line_q : in_line;
  assign src_rw   = req_pend_q ? lat_rw_q   : RW;
  assign tbi_beat = !(line_q && !BURST_EN);
  assign col_next = {col_q[MA_W-1:2], col_q[1:0] + 2'd1};
  assign unused_bits = ^{A, TT};

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  beat_d = beat_q;
    ref_cnt_d = ref_cnt_q;  ref_pend_d = ref_pend_q;  req_pend_d = req_pend_q;
    lat_bank_d = lat_bank_q;  lat_row_d = lat_row_q;  lat_col_d = lat_col_q;
    lat_mask_d = lat_mask_q;  lat_line_d = lat_line_q;  lat_rw_d = lat_rw_q;
    bank_d = bank_q;  col_d = col_q;  mask_d = mask_q;  line_d = line_q;
    nta_d = nta_q;  ntbi_d = ntbi_q;  dramrw_d = dramrw_q;
    drama_d = drama_q;  nras_d = nras_q;  ncas_d = ncas_q;

    if (new_req) begin
      lat_bank_d = in_bank;  lat_row_d = in_row;  lat_col_d = in_col;
      lat_mask_d = in_mask;  lat_line_d = in_line;  lat_rw_d = RW;
      req_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          ref_pend_d = 1'b0;
          ncas_d     = '0;
          state_d    = S_REFC;
        end else if (req_pend_q || new_req) begin
          // a request arriving while one is latched refills the latch
          req_pend_d = req_pend_q && new_req;
          bank_d   = src_bank;  col_d = src_col;  mask_d = src_mask;  line_d = src_line;
          drama_d  = src_row;
          nras_d   = ~(NBANK'(1) << src_bank);
          dramrw_d = src_rw;
          cnt_d    = C_RCD;
          beat_d   = 2'd0;
          state_d  = S_RCD;
        end
      end
      S_RCD: begin
        if (!nMI) begin
          nras_d = '1;  dramrw_d = 1'b1;  cnt_d = C_RP;  state_d = S_PRE;
        end else if (cnt_q == '0) begin
          ncas_d = cas_pattern(bank_q, mask_q);
          cnt_d  = C_CAS;
          state_d = S_CASL;
          if (T_CAS == 1) begin nta_d = 1'b0; ntbi_d = tbi_beat; end
        end else begin
          if (cnt_q == CW'(1)) drama_d = col_q;
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CASL: begin
        if (cnt_q == '0) begin
          nta_d = 1'b1;  ntbi_d = 1'b1;  ncas_d = '1;
          if (line_q && BURST_EN && beat_q != 2'd3) begin
            beat_d  = beat_q + 2'd1;
            col_d   = col_next;
            drama_d = col_next;
            cnt_d   = C_CP;
            state_d = S_CASH;
          end else begin
            nras_d = '1;  dramrw_d = 1'b1;  cnt_d = C_RP;  state_d = S_PRE;
          end
        end else begin
          if (cnt_q == CW'(1)) begin nta_d = 1'b0; ntbi_d = tbi_beat; end
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CASH: begin
        if (cnt_q == '0) begin
          ncas_d  = cas_pattern(bank_q, mask_q);
          cnt_d   = C_CAS;
          state_d = S_CASL;
          if (T_CAS == 1) begin nta_d = 1'b0; ntbi_d = tbi_beat; end
        end else cnt_d = cnt_q - 1'b1;
      end
      S_PRE: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      S_REFC: begin
        nras_d = '0;  cnt_d = C_REF;  state_d = S_REFR;
      end
      S_REFR: begin
        if (cnt_q == '0) begin
          nras_d = '1;  ncas_d = '1;  cnt_d = C_RP;  state_d = S_PRE;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d  = '0;
      ref_pend_d = 1'b1;
    end else ref_cnt_d = ref_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;  cnt_q <= '0;  beat_q <= '0;
      ref_cnt_q <= '0;  ref_pend_q <= 1'b0;  req_pend_q <= 1'b0;
      lat_bank_q <= '0;  lat_row_q <= '0;  lat_col_q <= '0;
      lat_mask_q <= '0;  lat_line_q <= 1'b0;  lat_rw_q <= 1'b1;
      bank_q <= '0;  col_q <= '0;  mask_q <= '0;  line_q <= 1'b0;
      nta_q <= 1'b1;  ntbi_q <= 1'b1;  dramrw_q <= 1'b1;
      drama_q <= '0;  nras_q <= '1;  ncas_q <= '1;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  beat_q <= beat_d;
      ref_cnt_q <= ref_cnt_d;  ref_pend_q <= ref_pend_d;  req_pend_q <= req_pend_d;
      lat_bank_q <= lat_bank_d;  lat_row_q <= lat_row_d;  lat_col_q <= lat_col_d;
      lat_mask_q <= lat_mask_d;  lat_line_q <= lat_line_d;  lat_rw_q <= lat_rw_d;
      bank_q <= bank_d;  col_q <= col_d;  mask_q <= mask_d;  line_q <= line_d;
      nta_q <= nta_d;  ntbi_q <= ntbi_d;  dramrw_q <= dramrw_d;
      drama_q <= drama_d;  nras_q <= nras_d;  ncas_q <= ncas_d;
    end
  end

  assign nTA    = nta_q;
  assign nTBI   = ntbi_q;
  assign DRAMA  = drama_q;
  assign nRAS   = nras_q;
  assign nCAS   = ncas_q;
  assign DRAMRW = dramrw_q;
endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: table of single accesses on a burst-capable instance, then
// hand sequences for nMI abort, reset mid-burst, CBR refresh, latching and nTBI.
module tb_dram_ctrl;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET, RW, nTS, SEL, nMI;
  logic [31:0] A;
  logic [1:0]  TT, SIZ;

  logic        nta1, ntbi1, dramrw1, nta2, ntbi2, dramrw2;
  logic [10:0] drama1, drama2;
  logic [3:0]  nras1, nras2;
  logic [15:0] ncas1, ncas2;

  dram_ctrl #(.REF_INT(4000)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .A(A), .TT(TT), .SIZ(SIZ), .RW(RW), .nTS(nTS), .SEL(SEL),
    .nMI(nMI), .nTA(nta1), .nTBI(ntbi1), .DRAMA(drama1), .nRAS(nras1), .nCAS(ncas1),
    .DRAMRW(dramrw1));

  dram_ctrl #(.REF_INT(16), .BURST_EN(1'b0)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .A(A), .TT(TT), .SIZ(SIZ), .RW(RW), .nTS(nTS), .SEL(SEL),
    .nMI(nMI), .nTA(nta2), .nTBI(ntbi2), .DRAMA(drama2), .nRAS(nras2), .nCAS(ncas2),
    .DRAMRW(dramrw2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [31:0]      a;
    logic [1:0]       siz;
    logic [1:0]       tt;
    logic             rw;
    logic             sel;
    logic             active;
    logic [3:0]       nras;
    logic [15:0]      ncas;
    logic [10:0]      row;
    logic [3:0][10:0] cols;
    int               beats;
  } vec_t;

  vec_t vecs[8];

  logic [15:0] cap_ncas  [24];
  logic [3:0]  cap_nras  [24];
  logic [10:0] cap_drama [24];
  logic        cap_nta   [24];
  logic        cap_ntbi  [24];
  logic        cap_rw    [24];

  // cap[i] holds dut1 outputs just after edge E0+i, E0 being the edge that sees nTS low
  task automatic issue_capture(input logic [31:0] a, input logic [1:0] siz, input logic [1:0] tt,
                               input logic rw, input logic sel);
    A = a; SIZ = siz; TT = tt; RW = rw; SEL = sel; nTS = 1'b0;
    step();
    nTS = 1'b1; SEL = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cap_ncas[i] = ncas1; cap_nras[i] = nras1; cap_drama[i] = drama1;
      cap_nta[i] = nta1; cap_ntbi[i] = ntbi1; cap_rw[i] = dramrw1;
      step();
    end
  endtask

  task automatic wait_refc(output int n);
    n = 0;
    while (!(ncas2 == 16'h0000 && nras2 == 4'hF) && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    int cnt_ta, cnt_tbi, any_ras, any_cas, n;

    vecs[0] = '{32'h0200_0404, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 4'b1011, 16'hF0FF, 11'h000,
                {4{11'h101}}, 1};
    vecs[1] = '{32'h0000_0002, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 4'b1110, 16'hFFFB, 11'h000,
                {4{11'h000}}, 1};
    vecs[2] = '{32'h0000_0018, 2'b11, 2'b01, 1'b1, 1'b1, 1'b1, 4'b1110, 16'hFFF0, 11'h000,
                {11'd5, 11'd4, 11'd7, 11'd6}, 4};
    vecs[3] = '{32'h0100_2003, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 4'b1101, 16'hFF3F, 11'h001,
                {4{11'h000}}, 1};
    vecs[4] = '{32'h03FF_FFFC, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 4'b0111, 16'h0FFF, 11'h7FF,
                {4{11'h7FF}}, 1};
    vecs[5] = '{32'h0300_000C, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 4'b0111, 16'h0FFF, 11'h000,
                {11'd2, 11'd1, 11'd0, 11'd3}, 4};
    vecs[6] = '{32'h0200_0404, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 4'b1111, 16'hFFFF, 11'h000,
                {4{11'h000}}, 0};
    vecs[7] = '{32'h0200_0404, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 4'b1111, 16'hFFFF, 11'h000,
                {4{11'h000}}, 0};

    RESET = 1'b1; A = '0; TT = 2'b00; SIZ = 2'b00; RW = 1'b1; nTS = 1'b1; SEL = 1'b0; nMI = 1'b1;
    repeat (3) step();
    chk("rst_nta",   {31'd0, nta1},    32'd1);
    chk("rst_ntbi",  {31'd0, ntbi1},   32'd1);
    chk("rst_rw",    {31'd0, dramrw1}, 32'd1);
    chk("rst_nras",  {28'd0, nras1},   32'hF);
    chk("rst_ncas",  {16'd0, ncas1},   32'hFFFF);
    chk("rst_drama", {21'd0, drama1},  32'd0);
    RESET = 1'b0;
    step();

    for (int v = 0; v < 8; v++) begin
      issue_capture(vecs[v].a, vecs[v].siz, vecs[v].tt, vecs[v].rw, vecs[v].sel);
      cnt_ta = 0; cnt_tbi = 0; any_ras = 0;
      for (int i = 0; i < 24; i++) begin
        if (!cap_nta[i]) cnt_ta++;
        if (!cap_ntbi[i]) cnt_tbi++;
        if (cap_nras[i] != 4'hF) any_ras++;
      end
      chk($sformatf("v%0d_nta_count", v), cnt_ta, vecs[v].beats);
      chk($sformatf("v%0d_ntbi_count", v), cnt_tbi, 0);
      chk($sformatf("v%0d_nras_end", v), {28'd0, cap_nras[23]}, 32'hF);
      if (vecs[v].active) begin
        chk($sformatf("v%0d_nras", v), {28'd0, cap_nras[1]}, {28'd0, vecs[v].nras});
        chk($sformatf("v%0d_row", v), {21'd0, cap_drama[1]}, {21'd0, vecs[v].row});
        chk($sformatf("v%0d_dramrw", v), {31'd0, cap_rw[1]}, {31'd0, vecs[v].rw});
        chk($sformatf("v%0d_col0", v), {21'd0, cap_drama[2]}, {21'd0, vecs[v].cols[0]});
        chk($sformatf("v%0d_ncas_e3", v), {16'd0, cap_ncas[3]}, {16'd0, vecs[v].ncas});
        chk($sformatf("v%0d_nta_e3", v), {31'd0, cap_nta[3]}, 32'd1);
        for (int b = 0; b < vecs[v].beats; b++) begin
          chk($sformatf("v%0d_b%0d_nta", v, b), {31'd0, cap_nta[4+3*b]}, 32'd0);
          chk($sformatf("v%0d_b%0d_col", v, b), {21'd0, cap_drama[4+3*b]}, {21'd0, vecs[v].cols[b]});
          chk($sformatf("v%0d_b%0d_ncas", v, b), {16'd0, cap_ncas[4+3*b]}, {16'd0, vecs[v].ncas});
          chk($sformatf("v%0d_b%0d_nras", v, b), {28'd0, cap_nras[4+3*b]}, {28'd0, vecs[v].nras});
        end
      end else begin
        chk($sformatf("v%0d_ignored_ras", v), any_ras, 0);
      end
    end

    // nMI abort while the row is open
    A = 32'h0200_0404; SIZ = 2'b00; TT = 2'b00; RW = 1'b1; SEL = 1'b1; nTS = 1'b0;
    step();
    nTS = 1'b1; SEL = 1'b0;
    step();
    chk("nmi_rcd_nras", {28'd0, nras1}, 32'hB);
    nMI = 1'b0;
    step();
    nMI = 1'b1;
    chk("nmi_nras_high", {28'd0, nras1}, 32'hF);
    cnt_ta = 0; any_cas = 0;
    for (int i = 0; i < 10; i++) begin
      if (!nta1) cnt_ta++;
      if (ncas1 != 16'hFFFF) any_cas++;
      step();
    end
    chk("nmi_no_nta", cnt_ta, 0);
    chk("nmi_no_cas", any_cas, 0);

    // reset during a line burst
    A = 32'h0000_0018; SIZ = 2'b11; TT = 2'b00; RW = 1'b1; SEL = 1'b1; nTS = 1'b0;
    step();
    nTS = 1'b1; SEL = 1'b0;
    repeat (7) step();
    chk("burst_mid_nta", {31'd0, nta1}, 32'd0);
    RESET = 1'b1;
    step();
    chk("rstmid_nras", {28'd0, nras1}, 32'hF);
    chk("rstmid_ncas", {16'd0, ncas1}, 32'hFFFF);
    chk("rstmid_nta",  {31'd0, nta1},  32'd1);
    RESET = 1'b0;
    cnt_ta = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!nta1) cnt_ta++;
    end
    chk("rstmid_no_nta", cnt_ta, 0);

    // CBR refresh on the REF_INT=16 instance
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    wait_refc(n);
    chk("ref_seen", (n < 40) ? 32'd1 : 32'd0, 32'd1);
    step();
    chk("refr_nras", {28'd0, nras2}, 32'h0);
    chk("refr_ncas", {16'd0, ncas2}, 32'h0);
    step(); step();
    chk("refr_nras3", {28'd0, nras2}, 32'h0);
    step();
    chk("refpre_nras", {28'd0, nras2}, 32'hF);
    chk("refpre_ncas", {16'd0, ncas2}, 32'hFFFF);
    wait_refc(n);
    chk("ref_period", n + 4, 16);

    // request during REFR is held and served after precharge
    step();
    A = 32'h0200_0404; SIZ = 2'b00; TT = 2'b00; RW = 1'b1; SEL = 1'b1; nTS = 1'b0;
    step();
    nTS = 1'b1; SEL = 1'b0;
    chk("latch_refr_nras", {28'd0, nras2}, 32'h0);
    n = 0;
    while (nras2 != 4'b1011 && n < 20) begin step(); n++; end
    chk("latch_served", {28'd0, nras2}, 32'hB);
    cnt_ta = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!nta2) begin
        cnt_ta++;
        chk("latch_ncas", {16'd0, ncas2}, 32'hF0FF);
        chk("latch_rw", {31'd0, dramrw2}, 32'd1);
      end
    end
    chk("latch_nta_count", cnt_ta, 1);

    // line read with bursts disabled: one beat, nTBI with nTA
    wait_refc(n);
    chk("ref2_seen", (n < 40) ? 32'd1 : 32'd0, 32'd1);
    step();
    A = 32'h0000_0018; SIZ = 2'b11; TT = 2'b00; RW = 1'b1; SEL = 1'b1; nTS = 1'b0;
    step();
    nTS = 1'b1; SEL = 1'b0;
    n = 0;
    while (nras2 != 4'b1110 && n < 20) begin step(); n++; end
    chk("tbi_served", {28'd0, nras2}, 32'hE);
    cnt_ta = 0; cnt_tbi = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!ntbi2) cnt_tbi++;
      if (!nta2) begin
        cnt_ta++;
        chk("tbi_with_nta", {31'd0, ntbi2}, 32'd0);
        chk("tbi_col", {21'd0, drama2}, 32'd6);
        chk("tbi_ncas", {16'd0, ncas2}, 32'hFFF0);
      end
    end
    chk("tbi_nta_count", cnt_ta, 1);
    chk("tbi_ntbi_count", cnt_tbi, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
